// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants, state type and select-code mapping for the mux scan sequencer
package mux_scan_pkg;

    localparam int NUM_CH = 6;

    localparam logic [4:0] SEL_CH0 = 5'b00000;
    localparam logic [4:0] SEL_CH1 = 5'b00001;
    localparam logic [4:0] SEL_CH2 = 5'b00010;
    localparam logic [4:0] SEL_CH3 = 5'b00100;
    localparam logic [4:0] SEL_CH4 = 5'b01000;
    localparam logic [4:0] SEL_CH5 = 5'b10000;
    localparam logic [4:0] SEL_ERR = 5'b11111;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        SAMPLE,
        ERROR
    } state_t;

    // Out-of-range indices fall back to ch0 so no undefined code can reach the mux
    function automatic logic [4:0] ch_select(input logic [2:0] idx);
        case (idx)
            3'd0:    return SEL_CH0;
            3'd1:    return SEL_CH1;
            3'd2:    return SEL_CH2;
            3'd3:    return SEL_CH3;
            3'd4:    return SEL_CH4;
            3'd5:    return SEL_CH5;
            default: return SEL_CH0;
        endcase
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - load/decrement dwell counter with zero flag, load clamped to a minimum dwell of 2
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec,
    input  logic               clr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               zero
);

    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] load_val;

    // Counter holds dwell_eff - 1 so that dwell_eff cycles elapse before it reads zero
    always_comb begin
        load_val = (dwell < DWELL_W'(2)) ? DWELL_W'(1) : dwell - DWELL_W'(1);
    end

    // Load wins over clear; decrement saturates at zero instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clr) begin
            count <= '0;
        end else if (dec && (count != '0)) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - scans mux channels 0..5 with programmable dwell and emits tagged samples
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               error_in,
    input  logic               error_clr,
    input  logic [7:0]         mux_data,
    output logic [4:0]         select,
    output logic               sample_valid,
    output logic [2:0]         sample_ch,
    output logic [7:0]         sample_data,
    output logic               frame_done,
    output logic               error_active,
    output logic               busy
);

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t     state;
    logic [2:0] ch;
    logic       tmr_load;
    logic       tmr_dec;
    logic       tmr_clr;
    logic       tmr_zero;

    // Timer reloads on every channel start (which re-latches dwell) and idles at zero outside a scan
    always_comb begin
        tmr_load = 1'b0;
        if (!error_in) begin
            if (state == IDLE && enable) begin
                tmr_load = 1'b1;
            end else if (state == SAMPLE && ((ch != LAST_CH) || enable)) begin
                tmr_load = 1'b1;
            end
        end
        tmr_dec = (state == DWELL);
        tmr_clr = (state == IDLE) || (state == ERROR);
    end

    dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .clr   (tmr_clr),
        .dwell (dwell),
        .zero  (tmr_zero)
    );

    // Scan FSM with registered outputs; error_in overrides every state, including a pending sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch           <= '0;
            select       <= SEL_CH0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            frame_done   <= 1'b0;
            error_active <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (error_in) begin
                state        <= ERROR;
                select       <= SEL_ERR;
                error_active <= 1'b1;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state  <= DWELL;
                            ch     <= '0;
                            select <= ch_select(3'd0);
                            busy   <= 1'b1;
                        end
                    end
                    DWELL: begin
                        if (tmr_zero) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        sample_valid <= 1'b1;
                        sample_ch    <= ch;
                        sample_data  <= mux_data;
                        if (ch != LAST_CH) begin
                            ch     <= ch + 3'd1;
                            select <= ch_select(ch + 3'd1);
                            state  <= DWELL;
                        end else begin
                            frame_done <= 1'b1;
                            ch         <= '0;
                            select     <= SEL_CH0;
                            if (enable) begin
                                state <= DWELL;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ERROR: begin
                        if (error_clr) begin
                            state        <= IDLE;
                            ch           <= '0;
                            select       <= SEL_CH0;
                            error_active <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable = 1'b0;
    logic [15:0] dwell = 16'd0;
    logic        error_in = 1'b0;
    logic        error_clr = 1'b0;
    logic [7:0]  mux_data;
    logic [4:0]  select;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [7:0]  sample_data;
    logic        frame_done;
    logic        error_active;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_on = 1'b0;
    logic [7:0] salt = 8'h00;

    mux_scan_sequencer #(.DWELL_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .dwell        (dwell),
        .error_in     (error_in),
        .error_clr    (error_clr),
        .mux_data     (mux_data),
        .select       (select),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .frame_done   (frame_done),
        .error_active (error_active),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sensor mux: channel k returns 1<<k, optionally scrambled by salt
    always_comb begin
        logic [7:0] base;
        case (select)
            5'b00000: base = 8'h01;
            5'b00001: base = 8'h02;
            5'b00010: base = 8'h04;
            5'b00100: base = 8'h08;
            5'b01000: base = 8'h10;
            5'b10000: base = 8'h20;
            default:  base = 8'hFF;
        endcase
        mux_data = base ^ salt;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: scan position within a channel of length dwell_eff+1
    int m_mode = 0;   // 0 idle, 1 scanning, 2 error
    int m_ch = 0;
    int m_pos = 0;
    int m_len = 0;
    logic [4:0] e_select = 5'd0;
    logic       e_valid = 1'b0;
    logic [2:0] e_ch = 3'd0;
    logic [7:0] e_data = 8'd0;
    logic       e_frame = 1'b0;
    logic       e_err = 1'b0;
    logic       e_busy = 1'b0;

    function automatic logic [4:0] code_of(input int c);
        return (c == 0) ? 5'd0 : 5'(1 << (c - 1));
    endfunction

    function automatic int chan_len(input logic [15:0] d);
        int v = int'(d);
        return ((v < 2) ? 2 : v) + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_ch = 0; m_pos = 0; m_len = 0;
            e_select = 5'd0; e_valid = 1'b0; e_ch = 3'd0; e_data = 8'd0;
            e_frame = 1'b0; e_err = 1'b0; e_busy = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_frame = 1'b0;
            if (error_in) begin
                m_mode = 2; e_select = 5'h1F; e_err = 1'b1; e_busy = 1'b0;
            end else if (m_mode == 0) begin
                if (enable) begin
                    m_mode = 1; m_ch = 0; m_pos = 0; m_len = chan_len(dwell);
                    e_select = code_of(0); e_busy = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (m_pos == m_len - 1) begin
                    e_valid = 1'b1; e_ch = 3'(m_ch); e_data = mux_data;
                    m_pos = 0; m_len = chan_len(dwell);
                    if (m_ch == 5) begin
                        e_frame = 1'b1; m_ch = 0;
                        if (!enable) begin
                            m_mode = 0; e_busy = 1'b0;
                        end
                    end else begin
                        m_ch++;
                    end
                    e_select = code_of(m_ch);
                end else begin
                    m_pos++;
                end
            end else begin
                if (error_clr) begin
                    m_mode = 0; e_select = 5'd0; e_err = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("select", int'(select), int'(e_select));
            chk("sample_valid", int'(sample_valid), int'(e_valid));
            chk("sample_ch", int'(sample_ch), int'(e_ch));
            chk("sample_data", int'(sample_data), int'(e_data));
            chk("frame_done", int'(frame_done), int'(e_frame));
            chk("error_active", int'(error_active), int'(e_err));
            chk("busy", int'(busy), int'(e_busy));
        end
    end

    // Sample log and timing marks for the literal expectations
    typedef struct { int ch; int data; int cyc; } smp_t;
    smp_t q[$];
    int start_cyc = 0;
    int frame_cyc = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (sample_valid) q.push_back('{int'(sample_ch), int'(sample_data), cyc});
        if (busy && !busy_prev) start_cyc = cyc;
        if (frame_done) frame_cyc = cyc;
        busy_prev = busy;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind 0: sample of channel arg, 1: frame_done, 2: select == arg
    task automatic wait_for(input int kind, input int arg, input int budget, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (kind)
                0: hit = sample_valid && (int'(sample_ch) == arg);
                1: hit = frame_done;
                default: hit = (int'(select) == arg);
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        step(1);
        enable = 1'b0;
    endtask

    logic [7:0] exp_seq [6];

    initial begin
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04;
        exp_seq[3] = 8'h08; exp_seq[4] = 8'h10; exp_seq[5] = 8'h20;

        rst_n = 1'b0;
        step(2);
        cmp_on = 1'b1;
        chk("reset_select", int'(select), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_error_active", int'(error_active), 0);
        rst_n = 1'b1;
        step(2);

        // Basic frame, dwell 4: 5-cycle channels, walking-one data
        q.delete();
        dwell = 16'd4;
        pulse_enable();
        wait_for(1, 0, 80, "frame_dwell4");
        step(2);
        chk("t1_count", q.size(), 6);
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            chk("t1_ch", q[i].ch, i);
            chk("t1_data", q[i].data, int'(exp_seq[i]));
        end
        if (q.size() >= 2) chk("t1_period", q[1].cyc - q[0].cyc, 5);
        chk("t1_frame_latency", frame_cyc - start_cyc, 30);
        chk("t1_idle_select", int'(select), 0);
        chk("t1_idle_busy", int'(busy), 0);

        // dwell 0 and 1 both clamp to a 3-cycle channel period
        for (int dv = 0; dv < 2; dv++) begin
            q.delete();
            dwell = 16'(dv);
            pulse_enable();
            wait_for(1, 0, 60, "frame_short_dwell");
            step(2);
            chk("t2_count", q.size(), 6);
            for (int i = 0; i + 1 < q.size(); i++) chk("t2_period", q[i+1].cyc - q[i].cyc, 3);
            chk("t2_frame_latency", frame_cyc - start_cyc, 18);
        end

        // Back-to-back frames, enable dropped during ch2 of the second frame
        q.delete();
        salt = 8'h5A;
        dwell = 16'd3;
        enable = 1'b1;
        wait_for(1, 0, 60, "frame_b2b_first");
        wait_for(0, 1, 30, "b2b_ch1");
        enable = 1'b0;
        wait_for(1, 0, 60, "frame_b2b_second");
        step(3);
        chk("t3_count", q.size(), 12);
        if (q.size() >= 9) begin
            chk("t3_gap", q[6].cyc - q[5].cyc, 4);
            chk("t3_restart_ch", q[6].ch, 0);
            chk("t3_salted_data", q[8].data, 8'h5E);
        end
        chk("t3_idle_select", int'(select), 0);
        chk("t3_idle_busy", int'(busy), 0);
        salt = 8'h00;

        // Error during ch3 dwell; clear blocked while error_in is high
        q.delete();
        dwell = 16'd4;
        pulse_enable();
        wait_for(2, 5'b00100, 60, "select_ch3");
        error_in = 1'b1;
        step(1);
        chk("t4_err_select", int'(select), 5'h1F);
        chk("t4_err_active", int'(error_active), 1);
        error_clr = 1'b1;
        step(3);
        chk("t4_err_hold", int'(select), 5'h1F);
        error_in = 1'b0;
        step(1);
        chk("t4_exit_select", int'(select), 0);
        chk("t4_exit_active", int'(error_active), 0);
        error_clr = 1'b0;
        step(2);
        chk("t4_count", q.size(), 3);
        if (q.size() >= 3) chk("t4_last_ch", q[2].ch, 2);

        // Error raised in the ch1 sample cycle suppresses that sample
        q.delete();
        dwell = 16'd2;
        pulse_enable();
        wait_for(0, 0, 20, "t5_ch0");
        step(2);
        error_in = 1'b1;
        step(1);
        error_in = 1'b0;
        error_clr = 1'b1;
        step(1);
        error_clr = 1'b0;
        step(3);
        chk("t5_count", q.size(), 1);
        chk("t5_select", int'(select), 0);

        // Asynchronous reset mid-dwell of ch4, then restart from ch0
        dwell = 16'd4;
        enable = 1'b1;
        wait_for(2, 5'b01000, 60, "select_ch4");
        step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_select", int'(select), 0);
        chk("t6_rst_valid", int'(sample_valid), 0);
        chk("t6_rst_ch", int'(sample_ch), 0);
        chk("t6_rst_data", int'(sample_data), 0);
        chk("t6_rst_frame", int'(frame_done), 0);
        chk("t6_rst_err", int'(error_active), 0);
        chk("t6_rst_busy", int'(busy), 0);
        step(2);
        q.delete();
        rst_n = 1'b1;
        wait_for(0, 0, 20, "t6_restart_ch0");
        step(1);
        chk("t6_first_count", q.size(), 1);
        if (q.size() >= 1) chk("t6_first_ch", q[0].ch, 0);
        enable = 1'b0;
        wait_for(1, 0, 60, "t6_frame");
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
